matrix_scroll_ctrl: RTL
=======================

// Module: matrix_scroll_ctrl
// PURPOSE
//  Sequencer for the 8x8 LED-matrix digit scroller.
//  - Generates row-scan strobes and the per-row glyph ROM address (scroll offset + active row).
//  - Steps the scroll offset up or down at a programmable rate, dwelling when a digit is fully aligned.
//  - Latches the colour-enable selection tear-free at frame boundaries.
//  - Replaces the free-running divider, index and row counters that previously drove the rom_char lookup.
// PARAMETERS
//  SCAN_DIV     4096  clk cycles per row tick (>=2)
//  STEP_FRAMES  48    full 8-row frames per scroll step (>=1)
//  HOLD_FRAMES  96    frames dwelled when offset%8==0 (>=1; used only with SCROLL_DWELL_EN)
//  ADDR_MAX     80    highest scroll offset; glyph ROM spans 0..ADDR_MAX+7
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous, active-low reset
//  en           in   1  1 = scan and scroll; 0 = blank and hold
//  dir          in   1  0 = offset decrements (content moves down); 1 = offset increments
//  pause        in   1  1 = freeze scroll stepping; scanning continues
//  sel          in   2  colour select: bit0 = green, bit1 = red
//  row          out  8  one-hot row enable; 0 = blank
//  rom_addr     out  7  glyph ROM address for the active row
//  offset       out  7  current scroll offset, 0..ADDR_MAX
//  grn_en       out  1  green column enable
//  red_en       out  1  red column enable
//  frame_tick   out  1  1-cycle pulse on the row tick that completes row index 7
// BEHAVIOUR
//  Reset (rst=0 at posedge)
//  - row=0, rom_addr=0, offset=ADDR_MAX, grn_en=red_en=0, frame_tick=0.
//  - Row index cnt=0, prescaler=0, frame counter=0, state=IDLE.
//  Prescaler
//  - Counts 0..SCAN_DIV-1 while en=1; row_tick when count==SCAN_DIV-1.
//  - Cleared while en=0.
//  Row tick (registered, single cycle)
//  - cnt' = (first tick after IDLE) ? 0 : cnt+1 mod 8.
//  - row <= 8'h80 >> cnt'.
//  - rom_addr <= offset_eff + cnt', where offset_eff is the offset value after any step taken this cycle.
//  - row and rom_addr therefore change in the same cycle, with zero skew.
//  - rom_addr is 7-bit; ADDR_MAX+7 <= 127 by construction.
//  Frame boundary (row tick with cnt==7)
//  - frame_tick=1 for that cycle.
//  - {red_en,grn_en} <= sel.
//  - Frame counter advances.
//  - Offset changes only at frame boundaries, so no frame shows two offsets.
//  FSM states: IDLE, RUN, DWELL
//  - IDLE: row=0, offset held. en=1 -> RUN on the next cycle. First row tick is SCAN_DIV cycles later.
//  - RUN: on the frame boundary where frames_since_step==STEP_FRAMES-1, and pause=0, step the offset:
//      dir=0: offset-1, with 0 -> ADDR_MAX
//      dir=1: offset+1, with ADDR_MAX -> 0
//    Frame counter clears on a step. If the new offset%8==0, go to DWELL.
//  - DWELL: no stepping. After HOLD_FRAMES frame boundaries, return to RUN with the frame counter cleared.
//  - en=0 from any state -> IDLE on the next cycle: row=0, cnt=0, prescaler cleared, offset and enables held.
//  Corner cases
//  - pause=1 on a step-due boundary: no step, and the frame counter saturates at STEP_FRAMES-1.
//    The step occurs on the first boundary after pause falls.
//  - pause=1 during DWELL does not stop the dwell count.
//  - dir is sampled only when a step is taken, so a change mid-frame has no partial effect.
//  - Reset mid-frame overrides everything on that edge.
// CONFIGURATION
//  SCROLL_DWELL_EN defined: DWELL state and HOLD_FRAMES behave as above.
//  SCROLL_DWELL_EN undefined: DWELL is never entered; RUN steps uniformly every STEP_FRAMES frames.
// STRUCTURE
//  Package matrix_pkg:
//  - state enum {IDLE,RUN,DWELL}.
//  - ROW_FIRST=8'h80, ROWS=8.
//  - ADDR_W=7.
//  Sub-module tick_prescaler: parameterised modulo-N counter with clear, producing the row_tick pulse.
//  Top level holds the FSM, row and offset registers.
// TESTING (SCAN_DIV=4, STEP_FRAMES=2, HOLD_FRAMES=3, SCROLL_DWELL_EN on unless noted)
//  1 Reset: rst=0 for 2 cycles -> row=0, offset=80, rom_addr=0, grn_en=red_en=0, frame_tick=0.
//  2 en=1, dir=0, sel=01: first tick 4 cycles after RUN -> row=80h, rom_addr=80.
//    frame_tick after 8 ticks, grn_en=1. After 2 frames offset=79, next row 80h has rom_addr=79.
//  3 Offset=1, dir=0: step -> 0 -> DWELL, 3 frames without a step, then 2 frames -> 80.
//    With SCROLL_DWELL_EN off: 0 -> 80 after 2 frames.
//  4 Offset=80, dir=1: step -> 0, and rom_addr for rows 0..7 is 0..7.
//  5 pause=1 across a due boundary: offset unchanged, rows keep cycling.
//    pause=0 -> step on the next boundary. sel changed mid-frame -> enables update only on frame_tick.
//  6 en=0 at row 3 -> next cycle row=0, offset held. Re-enable -> first tick gives row=80h, rom_addr=offset.

Source files
------------

// File: rtl/matrix_scroll_ctrl_pkg.sv
// Shared types and constants for the LED-matrix scroll sequencer.
//   state_e   : sequencer FSM states
//   ROW_FIRST : one-hot enable of row index 0 (top row, MSB)
//   ROWS      : rows per frame
//   ADDR_W    : glyph ROM address / scroll offset width
//   max_u     : larger of two unsigned values, used for counter sizing
package matrix_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DWELL
  } state_e;

  localparam logic [7:0]  ROW_FIRST = 8'h80;
  localparam int unsigned ROWS      = 8;
  localparam int unsigned ADDR_W    = 7;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/matrix_scroll_ctrl_if.sv
// Control/display bundle between the scroll host and the sequencer.
//   en, dir, pause, sel : host controls (driven by master)
//   row                 : one-hot row enable, 0 = blank
//   rom_addr            : glyph ROM address for the active row
//   offset              : current scroll offset
//   grn_en, red_en      : colour column enables, frame-aligned
//   frame_tick          : one-cycle pulse at each frame boundary
// master = host side, slave = sequencer side.
interface matrix_scroll_ctrl_if;

  logic                               en;
  logic                               dir;
  logic                               pause;
  logic [1:0]                         sel;
  logic [matrix_pkg::ROWS-1:0]        row;
  logic [matrix_pkg::ADDR_W-1:0]      rom_addr;
  logic [matrix_pkg::ADDR_W-1:0]      offset;
  logic                               grn_en;
  logic                               red_en;
  logic                               frame_tick;

  modport master (
    output en, dir, pause, sel,
    input  row, rom_addr, offset, grn_en, red_en, frame_tick
  );

  modport slave (
    input  en, dir, pause, sel,
    output row, rom_addr, offset, grn_en, red_en, frame_tick
  );

endinterface

// File: rtl/matrix_scroll_ctrl_tick_prescaler.sv
// Modulo-N counter producing the row-tick strobe.
//   i_clk   : clock
//   i_rst_n : synchronous active-low reset
//   i_clr   : synchronous clear (holds count at 0)
//   o_tick  : high while count == N-1 (one cycle in every N when not cleared)
module tick_prescaler #(
  parameter int unsigned N = 4096
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned W    = (N <= 2) ? 1 : $clog2(N);
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_tick = (r_count == LAST);

endmodule

// File: rtl/matrix_scroll_ctrl.sv
// Row-scan and scroll sequencer for the 8x8 LED-matrix digit scroller.
// Drives one-hot row strobes with a zero-skew glyph ROM address, steps the
// scroll offset every STEP_FRAMES frames, and latches colour enables at frame
// boundaries.
//   i_clk   : clock
//   i_rst_n : synchronous active-low reset
//   io_bus  : matrix_scroll_ctrl_if.slave (controls in, display signals out)
// Optional feature: define SCROLL_DWELL_EN to dwell HOLD_FRAMES frames whenever
// a step lands on a digit-aligned offset (offset % 8 == 0).
module matrix_scroll_ctrl
  import matrix_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 4096,
  parameter int unsigned STEP_FRAMES = 48,
  parameter int unsigned HOLD_FRAMES = 96,
  parameter int unsigned ADDR_MAX    = 80
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  matrix_scroll_ctrl_if.slave  io_bus
);

  localparam int unsigned FRAME_MAX = max_u(STEP_FRAMES, HOLD_FRAMES);
  localparam int unsigned FRAME_W   = (FRAME_MAX <= 2) ? 1 : $clog2(FRAME_MAX);
  localparam logic [FRAME_W-1:0] STEP_LAST = FRAME_W'(STEP_FRAMES - 1);
  localparam logic [FRAME_W-1:0] HOLD_LAST = FRAME_W'(HOLD_FRAMES - 1);
  localparam logic [ADDR_W-1:0]  OFF_MAX   = ADDR_W'(ADDR_MAX);

  state_e              r_state;
  logic [2:0]          r_cnt;
  logic                r_first;      // next row tick restarts at row 0
  logic [FRAME_W-1:0]  r_frames;     // frames since step, or dwell frames
  logic [7:0]          r_row;
  logic [ADDR_W-1:0]   r_rom_addr;
  logic [ADDR_W-1:0]   r_offset;
  logic                r_grn_en;
  logic                r_red_en;
  logic                r_frame_tick;

  logic                w_presc_tick;
  logic                w_presc_clr;
  logic                w_row_tick;
  logic                w_frame_end;
  logic                w_step;
  logic                w_dwell_go;
  logic [2:0]          w_cnt_nxt;
  logic [ADDR_W-1:0]   w_off_stepped;
  logic [ADDR_W-1:0]   w_off_eff;

  // Prescaler only runs in RUN/DWELL so the first tick lands SCAN_DIV cycles after IDLE exits.
  assign w_presc_clr = !io_bus.en || (r_state == IDLE);

  tick_prescaler #(
    .N (SCAN_DIV)
  ) u_presc (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_presc_clr),
    .o_tick  (w_presc_tick)
  );

  always_comb begin
    w_row_tick  = w_presc_tick && io_bus.en && (r_state != IDLE);
    w_frame_end = w_row_tick && !r_first && (r_cnt == 3'd7);
    w_cnt_nxt   = r_first ? 3'd0 : r_cnt + 3'd1;

    if (io_bus.dir) begin
      w_off_stepped = (r_offset == OFF_MAX) ? '0 : r_offset + ADDR_W'(1);
    end else begin
      w_off_stepped = (r_offset == '0) ? OFF_MAX : r_offset - ADDR_W'(1);
    end

    w_step    = w_frame_end && (r_state == RUN) && (r_frames == STEP_LAST) && !io_bus.pause;
    // rom_addr must use the post-step offset so the new frame is consistent from row 0.
    w_off_eff = w_step ? w_off_stepped : r_offset;

`ifdef SCROLL_DWELL_EN
    w_dwell_go = (w_off_stepped[2:0] == 3'd0);
`else
    w_dwell_go = 1'b0;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_first      <= 1'b1;
      r_frames     <= '0;
      r_row        <= '0;
      r_rom_addr   <= '0;
      r_offset     <= OFF_MAX;
      r_grn_en     <= 1'b0;
      r_red_en     <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= 1'b0;
      if (!io_bus.en) begin
        // Blank and hold offset/enables; clearing the frame count keeps RUN stepping sane.
        r_state  <= IDLE;
        r_row    <= '0;
        r_cnt    <= '0;
        r_first  <= 1'b1;
        r_frames <= '0;
      end else begin
        unique case (r_state)
          IDLE: r_state <= RUN;
          RUN: begin
            if (w_frame_end) begin
              if (w_step) begin
                r_offset <= w_off_stepped;
                r_frames <= '0;
                if (w_dwell_go) r_state <= DWELL;
              end else if (r_frames != STEP_LAST) begin
                r_frames <= r_frames + FRAME_W'(1);
              end
              // else: step due but paused -> counter saturates
            end
          end
          DWELL: begin
            if (w_frame_end) begin
              if (r_frames == HOLD_LAST) begin
                r_state  <= RUN;
                r_frames <= '0;
              end else begin
                r_frames <= r_frames + FRAME_W'(1);
              end
            end
          end
          default: r_state <= IDLE;
        endcase

        if (w_frame_end) begin
          r_frame_tick <= 1'b1;
          r_grn_en     <= io_bus.sel[0];
          r_red_en     <= io_bus.sel[1];
        end

        if (w_row_tick) begin
          r_cnt      <= w_cnt_nxt;
          r_first    <= 1'b0;
          r_row      <= ROW_FIRST >> w_cnt_nxt;
          r_rom_addr <= w_off_eff + ADDR_W'(w_cnt_nxt);
        end
      end
    end
  end

  assign io_bus.row        = r_row;
  assign io_bus.rom_addr   = r_rom_addr;
  assign io_bus.offset     = r_offset;
  assign io_bus.grn_en     = r_grn_en;
  assign io_bus.red_en     = r_red_en;
  assign io_bus.frame_tick = r_frame_tick;

endmodule
